// File: rtl/decode_sb.sv
// Decode stage: RV32 format/immediate decode, regfile read, busy-bit scoreboard for RAW hazards.
// Latency: 1 cycle from acceptance (valid_i & ready_o) to valid_ro.
// Backpressure: holds the output slice while valid_ro & ~ready_i; stalls input on hazard or flush.
// Optional: define DECODE_WB_BYPASS_EN to forward same-cycle writeback data and skip the busy stall.
module decode_sb #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic [RW-1:0]   rs1_o,
  output logic [RW-1:0]   rs2_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            wb_valid_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            valid_ro,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_ro,
  output logic [31:0]     inst_ro,
  output logic [XLEN-1:0] rs1_data_ro,
  output logic [XLEN-1:0] rs2_data_ro,
  output logic [XLEN-1:0] imm_ro,
  output logic [5:0]      fmt_ro,
  output logic [RW-1:0]   rd_ro,
  output logic            wen_ro,
  output logic            illegal_ro
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J     = 7'b1101111;

  // one-hot format bits {J,U,B,S,I,R}
  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            r_valid;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic [5:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_use1;
  logic            w_use2;
  logic            w_wen;
  logic            w_illegal;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_haz;
  logic            w_cke;
  logic            w_hs;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  assign w_rs1 = inst_i[15 +: RW];
  assign w_rs2 = inst_i[20 +: RW];
  assign w_rd  = inst_i[7 +: RW];
  assign rs1_o = w_rs1;
  assign rs2_o = w_rs2;

  // Format, source usage and 32-bit immediate from the opcode
  always_comb begin
    w_fmt   = '0;
    w_imm32 = '0;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    case (inst_i[6:0])
      OP_R: begin
        w_fmt  = FMT_R;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_fmt   = FMT_I;
        w_use1  = 1'b1;
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_S: begin
        w_fmt   = FMT_S;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_B: begin
        w_fmt   = FMT_B;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt   = FMT_U;
        w_imm32 = {inst_i[31:12], 12'b0};
      end
      OP_J: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: begin
        w_fmt = '0;
      end
    endcase
  end

  // every format carries its sign in inst[31], so a signed widen finishes the extension
  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_illegal = (w_fmt == 6'b0);
  assign w_wen     = (w_fmt[0] | w_fmt[1] | w_fmt[4] | w_fmt[5]) & (w_rd != '0);

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp1 = wb_valid_i & (wb_rd_i == w_rs1) & (w_rs1 != '0);
  assign w_byp2 = wb_valid_i & (wb_rd_i == w_rs2) & (w_rs2 != '0);
  assign w_op1  = w_byp1 ? wb_data_i : rs1_data_i;
  assign w_op2  = w_byp2 ? wb_data_i : rs2_data_i;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^wb_data_i;
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_op1  = rs1_data_i;
  assign w_op2  = rs2_data_i;
`endif

  // an instruction still in the slice has not set its busy bit yet, so match it directly
  assign w_hit1 = r_valid & wen_ro & (rd_ro == w_rs1) & ~flush_i;
  assign w_hit2 = r_valid & wen_ro & (rd_ro == w_rs2) & ~flush_i;

  assign w_haz = (w_use1 & (w_rs1 != '0) & ((r_busy[w_rs1] & ~w_byp1) | w_hit1)) |
                 (w_use2 & (w_rs2 != '0) & ((r_busy[w_rs2] & ~w_byp2) | w_hit2));

  assign w_cke   = ~r_valid | ready_i;
  assign ready_o = w_cke & ~w_haz & ~flush_i;
  assign w_hs    = r_valid & ready_i & wen_ro & ~flush_i;

  // Scoreboard update: clear on writeback, then set on handoff so a set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid_i) begin
      w_busy_nxt[wb_rd_i] = 1'b0;
    end
    if (w_hs) begin
      w_busy_nxt[rd_ro] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Output valid: flush kills the slice regardless of ready_i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_cke) begin
      r_valid <= valid_i & ~w_haz;
    end
  end

  assign valid_ro = r_valid;

  // Output data slice: loads whenever the slice may advance, holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_ro       <= RESET_PC;
      inst_ro     <= 32'h0000_0013;
      rs1_data_ro <= '0;
      rs2_data_ro <= '0;
      imm_ro      <= '0;
      fmt_ro      <= '0;
      rd_ro       <= '0;
      wen_ro      <= 1'b0;
      illegal_ro  <= 1'b0;
    end else if (w_cke) begin
      pc_ro       <= pc_i;
      inst_ro     <= inst_i;
      rs1_data_ro <= w_op1;
      rs2_data_ro <= w_op2;
      imm_ro      <= w_imm;
      fmt_ro      <= w_fmt;
      rd_ro       <= w_rd;
      wen_ro      <= w_wen;
      illegal_ro  <= w_illegal;
    end
  end

endmodule

// File: tb/tb_decode_sb.sv
// Randomized bench for decode_sb with a cycle-level reference model of the decode rules.
// Latency: model predicts ready_o each cycle and the registered slice one cycle later.
// Backpressure: ready_i, flush_i and writebacks are randomized alongside directed scenarios.
module tb_decode_sb;
  localparam int          XLEN     = 32;
  localparam int          NREG     = 32;
  localparam int          RW       = 5;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     inst_i;
  logic [RW-1:0]   rs1_o;
  logic [RW-1:0]   rs2_o;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            wb_valid_i;
  logic [RW-1:0]   wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            flush_i;
  logic            valid_ro;
  logic            ready_i;
  logic [XLEN-1:0] pc_ro;
  logic [31:0]     inst_ro;
  logic [XLEN-1:0] rs1_data_ro;
  logic [XLEN-1:0] rs2_data_ro;
  logic [XLEN-1:0] imm_ro;
  logic [5:0]      fmt_ro;
  logic [RW-1:0]   rd_ro;
  logic            wen_ro;
  logic            illegal_ro;

  decode_sb #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .inst_i(inst_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
    .valid_ro(valid_ro), .ready_i(ready_i), .pc_ro(pc_ro), .inst_ro(inst_ro),
    .rs1_data_ro(rs1_data_ro), .rs2_data_ro(rs2_data_ro), .imm_ro(imm_ro), .fmt_ro(fmt_ro),
    .rd_ro(rd_ro), .wen_ro(wen_ro), .illegal_ro(illegal_ro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model state: the expected output slice and the set of pending registers
  bit          m_valid;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_imm;
  logic [5:0]  m_fmt;
  logic [4:0]  m_rd;
  bit          m_wen, m_ill;
  bit [31:0]   m_busy;

  task automatic model_reset();
    m_valid = 0; m_pc = RESET_PC; m_inst = 32'h13; m_r1 = 0; m_r2 = 0; m_imm = 0;
    m_fmt = 0; m_rd = 0; m_wen = 0; m_ill = 0; m_busy = 0;
  endtask

  // decode from the ISA tables using integer arithmetic on the immediate fields
  function automatic void dec(input logic [31:0] ins, output logic [5:0] f, output logic [31:0] imm,
                              output bit u1, output bit u2, output bit w);
    int s;
    s = $signed(ins);
    f = 0; imm = 0; u1 = 0; u2 = 0;
    case (ins[6:0])
      7'h33: begin f = 6'd1; u1 = 1; u2 = 1; end
      7'h13, 7'h03, 7'h67: begin f = 6'd2; u1 = 1; imm = s >>> 20; end
      7'h23: begin f = 6'd4; u1 = 1; u2 = 1; imm = (s >>> 25) * 32 + int'(ins[11:7]); end
      7'h63: begin
        f = 6'd8; u1 = 1; u2 = 1;
        imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin f = 6'd16; imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        f = 6'd32;
        imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      default: f = 0;
    endcase
    w = (f == 6'd1 || f == 6'd2 || f == 6'd16 || f == 6'd32) && (ins[11:7] != 0);
  endfunction

  function automatic bit byp(input logic [4:0] s);
`ifdef DECODE_WB_BYPASS_EN
    return wb_valid_i && wb_rd_i == s && s != 0;
`else
    return 0;
`endif
  endfunction

  function automatic bit src_haz(input logic [4:0] s);
    if (s == 0) return 0;
    return (m_busy[s] && !byp(s)) || (m_valid && m_wen && m_rd == s && !flush_i);
  endfunction

  // one clock: check the combinational outputs, advance the model, check the registered slice
  task automatic step();
    logic [5:0] f; logic [31:0] imm; bit u1, u2, w, haz, cke, hs;
    logic [4:0] s1, s2; bit [31:0] nb;
    bit n_valid; logic [31:0] n_pc, n_inst, n_r1, n_r2, n_imm; logic [5:0] n_fmt; logic [4:0] n_rd;
    bit n_wen, n_ill;
    #2;
    s1 = inst_i[19:15]; s2 = inst_i[24:20];
    dec(inst_i, f, imm, u1, u2, w);
    haz = (u1 && src_haz(s1)) || (u2 && src_haz(s2));
    cke = !m_valid || ready_i;
    chk("ready_o", ready_o, cke && !haz && !flush_i);
    chk("rs1_o", rs1_o, s1);
    chk("rs2_o", rs2_o, s2);
    nb = m_busy;
    if (wb_valid_i && wb_rd_i != 0) nb[wb_rd_i] = 0;
    hs = m_valid && ready_i && m_wen && !flush_i;
    if (hs) nb[m_rd] = 1;
    n_valid = flush_i ? 0 : (cke ? (valid_i && !haz) : m_valid);
    {n_pc, n_inst, n_r1, n_r2, n_imm, n_fmt, n_rd, n_wen, n_ill} =
      {m_pc, m_inst, m_r1, m_r2, m_imm, m_fmt, m_rd, m_wen, m_ill};
    if (cke) begin
      n_pc = pc_i; n_inst = inst_i; n_imm = imm; n_fmt = f; n_rd = inst_i[11:7];
      n_wen = w; n_ill = (f == 0);
      n_r1 = byp(s1) ? wb_data_i : rs1_data_i;
      n_r2 = byp(s2) ? wb_data_i : rs2_data_i;
    end
    @(posedge clk); #1;
    m_busy = nb; m_valid = n_valid;
    {m_pc, m_inst, m_r1, m_r2, m_imm, m_fmt, m_rd, m_wen, m_ill} =
      {n_pc, n_inst, n_r1, n_r2, n_imm, n_fmt, n_rd, n_wen, n_ill};
    chk("valid_ro", valid_ro, m_valid);
    chk("pc_inst", {pc_ro, inst_ro}, {m_pc, m_inst});
    chk("operands", {rs1_data_ro, rs2_data_ro}, {m_r1, m_r2});
    chk("imm_ro", imm_ro, m_imm);
    chk("fmt_rd_wen_ill", {fmt_ro, rd_ro, wen_ro, illegal_ro}, {m_fmt, m_rd, m_wen, m_ill});
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit rdy,
                       input bit fl, input bit wbv, input logic [4:0] wbr, input logic [31:0] wbd);
    valid_i = v; inst_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
    wb_valid_i = wbv; wb_rd_i = wbr; wb_data_i = wbd;
    rs1_data_i = $urandom; rs2_data_i = $urandom;
    step();
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2; k++)
      for (int r = 1; r < 32; r++) drive(0, 32'h13, 0, 1, 0, 1, 5'(r), 0);
  endtask

  logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};

  initial begin
    rst = 1; valid_i = 0; pc_i = 0; inst_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0; flush_i = 0; ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_ro, 0);
    chk("rst_pc_inst", {pc_ro, inst_ro}, {RESET_PC, 32'h13});
    chk("rst_fields", {rs1_data_ro, rs2_data_ro, imm_ro, fmt_ro, rd_ro, wen_ro, illegal_ro}, 0);
    model_reset();
    rst = 0;

    // addi x1,x0,5 accepted, held in the slice
    drive(1, 32'h0050_0093, 32'h100, 0, 0, 0, 0, 0);
    chk("addi_vals", {valid_ro, pc_ro, imm_ro, fmt_ro, rd_ro, wen_ro}, {1'b1, 32'h100, 32'd5, 6'b000010, 5'd1, 1'b1});
    // add x2,x1,x1 behind it: slice hit, then busy, then writeback releases it
    drive(1, 32'h0010_8133, 32'h104, 1, 0, 0, 0, 0);
    drive(1, 32'h0010_8133, 32'h104, 1, 0, 0, 0, 0);
    drive(1, 32'h0010_8133, 32'h104, 1, 0, 1, 1, 32'h5);
    drive(1, 32'h0010_8133, 32'h104, 1, 0, 0, 0, 0);
    clear_all();

    // sw x3,-4(x2) stalled three cycles
    drive(1, 32'hFE31_2E23, 32'h200, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 32'h13, 0, 0, 0, 0, 0, 0);
    chk("sw_held", {valid_ro, pc_ro, imm_ro, fmt_ro}, {1'b1, 32'h200, 32'hFFFF_FFFC, 6'b000100});

    // lui x5 flushed; busy[5] must stay clear so addi x6,x5,0 goes straight through
    drive(1, 32'h0001_22B7, 32'h300, 1, 0, 0, 0, 0);
    drive(1, 32'h0000_0013, 32'h304, 1, 1, 0, 0, 0);
    chk("flush_kills", valid_ro, 0);
    drive(1, 32'h0002_8313, 32'h308, 1, 0, 0, 0, 0);
    clear_all();

    // nop and an illegal opcode: no destination, no stall
    drive(1, 32'h0000_0013, 32'h400, 1, 0, 0, 0, 0);
    drive(1, 32'h0000_007F, 32'h404, 1, 0, 0, 0, 0);
    chk("illegal", {illegal_ro, fmt_ro, wen_ro}, {1'b1, 6'b0, 1'b0});
    drive(1, 32'h0000_0013, 32'h408, 1, 0, 0, 0, 0);

    // addi x7 handed off in the same cycle a writeback to x7 arrives: set wins
    drive(1, 32'h0010_0393, 32'h500, 1, 0, 0, 0, 0);
    drive(0, 32'h13, 0, 1, 0, 1, 7, 0);
    drive(1, 32'h0003_80B3, 32'h504, 1, 0, 0, 0, 0);
    drive(1, 32'h0003_80B3, 32'h504, 1, 0, 1, 7, 32'h77);
    drive(1, 32'h0003_80B3, 32'h504, 1, 0, 0, 0, 0);
    clear_all();

    // reset while the slice is stalled discards it
    drive(1, 32'h0050_0093, 32'h600, 0, 0, 0, 0, 0);
    drive(1, 32'h0000_0013, 32'h604, 0, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_midstall", {valid_ro, inst_ro, pc_ro}, {1'b0, 32'h13, RESET_PC});
    model_reset();
    rst = 0;

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 10)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_sb.md
Name: decode_sb

Overview:
- Parametrised RISC-V decode stage between fetch and execute.
- Decodes the instruction format and generates the sign-extended immediate.
- Reads the register file and holds an internal busy-bit scoreboard, so it detects RAW hazards itself with no external reservation signal.
- Registered valid/ready output slice with branch flush; an optional same-cycle writeback bypass.

Parameters:
- XLEN, 32, datapath / pc / immediate width.
- NREG, 32, architectural register count (16 for RV32E); register index width RW = $clog2(NREG).
- RESET_PC, 0, reset value of pc_ro.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  fetch offers pc_i/inst_i
- ready_o  out  1  decode accepts this cycle
- pc_i  in  XLEN  instruction address
- inst_i  in  32  instruction word
- rs1_o  out  RW  regfile read address 0 = inst_i[19:15] truncated to RW
- rs2_o  out  RW  regfile read address 1 = inst_i[24:20] truncated to RW
- rs1_data_i  in  XLEN  regfile read data 0 (combinational)
- rs2_data_i  in  XLEN  regfile read data 1 (combinational)
- wb_valid_i  in  1  writeback retiring a destination
- wb_rd_i  in  RW  writeback register
- wb_data_i  in  XLEN  writeback data (used only with the bypass feature)
- flush_i  in  1  kill output slice and current input
- valid_ro  out  1  output slice holds an instruction
- ready_i  in  1  execute accepts
- pc_ro  out  XLEN  registered pc
- inst_ro  out  32  registered instruction
- rs1_data_ro, rs2_data_ro  out  XLEN  registered operands
- imm_ro  out  XLEN  registered sign-extended immediate
- fmt_ro  out  6  one-hot {J,U,B,S,I,R}
- rd_ro  out  RW  destination register
- wen_ro  out  1  writes rd (format R/I/U/J and rd != 0)
- illegal_ro  out  1  opcode not among the nine base opcodes

Behaviour:
- Formats:
  - R = 0110011.
  - I = 0010011 / 0000011 / 1100111.
  - S = 0100011.
  - B = 1100011.
  - U = 0110111 / 0010111.
  - J = 1101111.
  - Anything else: fmt = 0, illegal = 1, no source/destination use.
- Source use: rs1 used by R/I/S/B; rs2 used by R/S/B.
- Immediate: standard RV32 encodings, sign-extended from inst[31] to XLEN. R and illegal produce imm = 0.
- Scoreboard: busy[NREG-1:0], reset 0; busy[0] is never set.
  - Set: busy[rd_ro] sets on downstream handshake (valid_ro & ready_i & wen_ro).
  - Clear: busy[wb_rd_i] clears on wb_valid_i.
  - Same register set and cleared in the same cycle: set wins.
  - wb to x0 is ignored.
- Hazard: a used source index s != 0 hazards when busy[s], OR (valid_ro & wen_ro & rd_ro == s & !flush_i).
  - Without the feature, a same-cycle wb_valid_i to s does NOT remove the hazard.
- Handshake: cke = ~valid_ro | ready_i.
  - ready_o = cke & ~hazard & ~flush_i.
  - On cke: valid_ro <= valid_i & ~hazard & ~flush_i, and all data fields load.
  - Latency: 1 cycle from acceptance to valid_ro.
  - Data fields hold while valid_ro & ~ready_i.
- flush_i has priority over everything: valid_ro <= 0 next cycle regardless of ready_i.
  - The killed slice never sets busy.
  - Busy bits of instructions already handed off stay set; the downstream stage must still assert wb (it may be a dummy) to release each one.
- Reset values: valid_ro=0, pc_ro=RESET_PC, inst_ro=0x00000013 (nop), data/imm=0, fmt_ro=0, rd_ro=0, wen_ro=0, illegal_ro=0, busy=0. Reset mid-stall discards the held instruction.
- rs1_o/rs2_o are driven purely from inst_i, independent of valid_i.

Optional Feature:
- DECODE_WB_BYPASS_EN.
  - Defined: when wb_valid_i & wb_rd_i == s (s != 0) this cycle, that source does not hazard on busy[s]. wb_data_i replaces rs*_data_i in the registered operand. Output-slice rd matches still hazard.
  - Undefined: wb_data_i is ignored; one extra stall cycle after each writeback to a pending register.

Test Plan:
- Reset, then valid_i=1, inst=0x00500093 (addi x1,x0,5), pc=0x100 -> next cycle valid_ro=1, fmt_ro=I, imm_ro=5, rd_ro=1, wen_ro=1, pc_ro=0x100.
- addi x1 handed off (ready_i=1), then add x2,x1,x1 (0x00108133) -> ready_o=0 while busy[1]. wb_valid_i with wb_rd=1 -> accepted the following cycle, or the same cycle with DECODE_WB_BYPASS_EN (rs1_data_ro = wb_data 0x5).
- ready_i=0 with sw x3,-4(x2) (0xFE312E23) in the slice -> all outputs stable for 3 cycles, imm_ro=0xFFFFFFFC, fmt_ro=S.
- flush_i=1 while valid_ro=1 with lui x5 in the slice -> valid_ro=0 next cycle, busy[5] stays 0, ready_o=0 during the flush cycle.
- addi x0,x0,0 then inst 0x0000007F -> wen_ro=0, busy unchanged; illegal_ro=1, fmt_ro=0, no stall.
- Handoff of rd=7 coincident with wb_rd=7 -> busy[7]=1 afterwards; a later wb to 7 clears it.
